// File: rtl/vanilla_fetch_pc.sv
// Fetch / PC-generation stage: issues word-addressed imem reads, buffers returns in a
// 2-entry bypass queue for decode, and redirects/squashes on taken branch or JALR.
// Optional perf counters are built when VANILLA_FETCH_PERF_CNT_EN is defined.
module vanilla_fetch_pc #(
  parameter int imem_addr_width_p = 10,
  parameter int reset_pc_p        = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         freeze_i,
  output logic                         imem_v_o,
  output logic [imem_addr_width_p-1:0] imem_addr_o,
  input  logic [31:0]                  imem_data_i,
  input  logic                         branch_v_i,
  input  logic                         jump_now_i,
  input  logic [imem_addr_width_p-1:0] branch_target_i,
  input  logic                         jalr_v_i,
  input  logic [imem_addr_width_p-1:0] jalr_addr_i,
  output logic                         instr_v_o,
  output logic [31:0]                  instr_o,
  output logic [31:0]                  pc_plus4_o,
`ifdef VANILLA_FETCH_PERF_CNT_EN
  output logic [31:0]                  fetch_cnt_o,
  output logic [31:0]                  squash_cnt_o,
`endif
  input  logic                         instr_yumi_i
);

  localparam int W = imem_addr_width_p;
  localparam logic [W-1:0] RESET_PC = W'(reset_pc_p);

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_e;

  // Handshake: decode may raise instr_yumi_i only while instr_v_o=1; the head is
  // consumed on that edge unless a redirect is accepted in the same cycle.

  state_e          w_state;
  logic [W-1:0]    r_pc;
  logic [W-1:0]    r_inflight_pc;
  logic            r_inflight;
  logic            r_squash;
  logic [1:0]      r_count;
  logic [31:0]     r_fifo_instr [2];
  logic [W-1:0]    r_fifo_pc    [2];
  logic [31:0]     r_hold_instr;
  logic [31:0]     r_hold_pc4;

  logic            w_redirect;
  logic [W-1:0]    w_target;
  logic            w_ret;
  logic            w_head_v;
  logic            w_deq;
  logic            w_fifo_deq;
  logic            w_enq;
  logic            w_wr_idx;
  logic            w_issue;
  logic [2:0]      w_credit;
  logic [31:0]     w_head_instr;
  logic [W-1:0]    w_head_pc;
  logic [W-1:0]    w_head_pc_inc;
  logic [W+33:0]   w_pc4_wide;
  logic [31:0]     w_head_pc4;

  always_comb begin
    w_state = RUN;
    if (freeze_i) w_state = FROZEN;
  end

  assign w_redirect = jalr_v_i | (branch_v_i & jump_now_i);
  assign w_target   = jalr_v_i ? jalr_addr_i : branch_target_i;

  // A live return is presented to decode directly when the queue is empty.
  assign w_ret        = r_inflight & ~r_squash;
  assign w_head_v     = (r_count != 2'd0) | w_ret;
  assign w_head_instr = (r_count != 2'd0) ? r_fifo_instr[0] : imem_data_i;
  assign w_head_pc    = (r_count != 2'd0) ? r_fifo_pc[0]    : r_inflight_pc;

  assign instr_v_o  = w_head_v & ~reset_i;
  assign w_deq      = instr_yumi_i & instr_v_o & ~w_redirect;
  assign w_fifo_deq = w_deq & (r_count != 2'd0);
  assign w_enq      = w_ret & ~(w_deq & (r_count == 2'd0));
  assign w_wr_idx   = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_fifo_deq);

  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_issue  = (w_state == RUN) & ~w_redirect & ~reset_i & (w_credit < 3'd2);

  assign imem_v_o    = w_issue;
  assign imem_addr_o = r_pc;

  assign w_head_pc_inc = w_head_pc + 1'b1;
  assign w_pc4_wide    = {32'b0, w_head_pc_inc, 2'b00};
  assign w_head_pc4    = w_pc4_wide[31:0];

  assign instr_o    = reset_i ? 32'b0 : (instr_v_o ? w_head_instr : r_hold_instr);
  assign pc_plus4_o = reset_i ? 32'b0 : (instr_v_o ? w_head_pc4   : r_hold_pc4);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_squash      <= 1'b0;
      r_count       <= 2'd0;
      r_hold_instr  <= 32'b0;
      r_hold_pc4    <= 32'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (instr_v_o) begin
        r_hold_instr <= w_head_instr;
        r_hold_pc4   <= w_head_pc4;
      end
      if (w_redirect) begin
        r_pc     <= w_target;
        r_count  <= 2'd0;
        r_squash <= r_inflight;
      end else begin
        r_squash <= 1'b0;
        if (w_issue) r_pc <= r_pc + 1'b1;
        r_count <= r_count + {1'b0, w_enq} - {1'b0, w_fifo_deq};
      end
    end
  end

  // Queue storage needs no reset: r_count qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (w_fifo_deq) begin
      r_fifo_instr[0] <= r_fifo_instr[1];
      r_fifo_pc[0]    <= r_fifo_pc[1];
    end
    if (w_enq) begin
      r_fifo_instr[w_wr_idx] <= imem_data_i;
      r_fifo_pc[w_wr_idx]    <= r_inflight_pc;
    end
  end

`ifdef VANILLA_FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_cnt_o  <= 32'b0;
      squash_cnt_o <= 32'b0;
    end else begin
      if (w_issue) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (w_redirect) squash_cnt_o <= squash_cnt_o + 32'(r_count) + 32'(w_ret);
    end
  end
`endif

endmodule

// File: tb/tb_vanilla_fetch_pc.sv
// Directed bench for vanilla_fetch_pc: scoreboard of expected {instr, pc_plus4}
// popped by a monitor on every accepted handshake, plus cycle-exact point checks.
module tb_vanilla_fetch_pc;
  localparam int W = 6;

  logic          clk = 1'b0;
  logic          reset_i, freeze_i;
  logic          imem_v_o;
  logic [W-1:0]  imem_addr_o;
  logic [31:0]   imem_data_i;
  logic          branch_v_i, jump_now_i, jalr_v_i;
  logic [W-1:0]  branch_target_i, jalr_addr_i;
  logic          instr_v_o;
  logic [31:0]   instr_o, pc_plus4_o;
  logic          instr_yumi_i;
`ifdef VANILLA_FETCH_PERF_CNT_EN
  logic [31:0]   fetch_cnt_o, squash_cnt_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  vanilla_fetch_pc #(.imem_addr_width_p(W), .reset_pc_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i),
    .imem_v_o(imem_v_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .branch_v_i(branch_v_i), .jump_now_i(jump_now_i), .branch_target_i(branch_target_i),
    .jalr_v_i(jalr_v_i), .jalr_addr_i(jalr_addr_i),
    .instr_v_o(instr_v_o), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
`ifdef VANILLA_FETCH_PERF_CNT_EN
    .fetch_cnt_o(fetch_cnt_o), .squash_cnt_o(squash_cnt_o),
`endif
    .instr_yumi_i(instr_yumi_i)
  );

  // Synchronous instruction memory: word at address a holds 0xC0DE0000 | a.
  always @(posedge clk) begin
    if (imem_v_o) imem_data_i <= 32'hC0DE_0000 | 32'(imem_addr_o);
  end

  function automatic logic [63:0] exp_of(input int a);
    logic [W-1:0] n;
    n = W'(a + 1);
    return {32'hC0DE_0000 | 32'(a), 24'b0, n, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every accepted instruction must match the head of the expected queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_i && instr_v_o && instr_yumi_i && !(jalr_v_i || (branch_v_i && jump_now_i))) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_underflow: got instr 0x%08h, expected none", instr_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instr_o, e[63:32]);
        check("sb_pc_plus4", pc_plus4_o, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset_i = 1'b1; freeze_i = 1'b0; instr_yumi_i = 1'b1;
    branch_v_i = 1'b0; jump_now_i = 1'b0; branch_target_i = '0;
    jalr_v_i = 1'b0; jalr_addr_i = '0;

    repeat (3) begin cyc(); smp(); end
    check("rst_imem_v", 32'(imem_v_o), 32'd0);
    check("rst_instr_v", 32'(instr_v_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc_plus4", pc_plus4_o, 32'd0);

    for (int a = 16; a <= 21; a++) exp_q.push_back(exp_of(a));

    cyc(); reset_i = 1'b0; smp();                    // cycle 1
    check("c1_imem_v", 32'(imem_v_o), 32'd1);
    check("c1_addr", 32'(imem_addr_o), 32'd16);
    check("c1_instr_v", 32'(instr_v_o), 32'd0);
    cyc(); smp();                                    // cycle 2
    check("c2_addr", 32'(imem_addr_o), 32'd17);
    check("c2_instr_v", 32'(instr_v_o), 32'd1);
    check("c2_pc_plus4", pc_plus4_o, 32'd68);
    cyc(); smp();
    check("c3_addr", 32'(imem_addr_o), 32'd18);

    cyc(); instr_yumi_i = 1'b0; smp();
    check("stall_last_issue", 32'(imem_addr_o), 32'd19);
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      check("credit_stall", 32'(imem_v_o), 32'd0);
    end
    check("full_head_v", 32'(instr_v_o), 32'd1);
    check("full_head", instr_o, 32'hC0DE_0012);

    for (int i = 0; i < 4; i++) begin
      cyc(); instr_yumi_i = 1'b1; smp();
      check("drain_no_gap", 32'(instr_v_o), 32'd1);
    end

    exp_q.push_back(exp_of(40));
    cyc(); instr_yumi_i = 1'b0; branch_v_i = 1'b1; jump_now_i = 1'b1; branch_target_i = 6'd40; smp();
    check("br_no_issue", 32'(imem_v_o), 32'd0);
    cyc(); branch_v_i = 1'b0; jump_now_i = 1'b0; instr_yumi_i = 1'b1; smp();
    check("br_n1_instr_v", 32'(instr_v_o), 32'd0);
    check("br_n1_imem_v", 32'(imem_v_o), 32'd1);
    check("br_n1_addr", 32'(imem_addr_o), 32'd40);
`ifdef VANILLA_FETCH_PERF_CNT_EN
    check("perf_squash_br", squash_cnt_o, 32'd2);
    check("perf_fetch", fetch_cnt_o, 32'd8);
`endif
    cyc(); smp();
    check("br_n2_instr_v", 32'(instr_v_o), 32'd1);
    check("br_n2_pc_plus4", pc_plus4_o, 32'd164);

    exp_q.push_back(exp_of(8));
    exp_q.push_back(exp_of(9));
    cyc(); instr_yumi_i = 1'b0; jalr_v_i = 1'b1; jalr_addr_i = 6'd8;
    branch_v_i = 1'b1; jump_now_i = 1'b1; branch_target_i = 6'd40; smp();
    cyc(); jalr_v_i = 1'b0; branch_v_i = 1'b0; jump_now_i = 1'b0; instr_yumi_i = 1'b1; smp();
    check("jalr_wins_addr", 32'(imem_addr_o), 32'd8);
    check("jalr_imem_v", 32'(imem_v_o), 32'd1);
    check("jalr_instr_v", 32'(instr_v_o), 32'd0);
`ifdef VANILLA_FETCH_PERF_CNT_EN
    check("perf_squash_jalr", squash_cnt_o, 32'd3);
`endif
    cyc(); smp();
    check("jalr_pc_plus4", pc_plus4_o, 32'd36);
    cyc(); smp();

    exp_q.push_back(exp_of(63));
    exp_q.push_back(exp_of(0));
    exp_q.push_back(exp_of(1));
    exp_q.push_back(exp_of(2));
    cyc(); instr_yumi_i = 1'b0; jalr_v_i = 1'b1; jalr_addr_i = 6'd63; smp();
    cyc(); jalr_v_i = 1'b0; instr_yumi_i = 1'b1; smp();
    check("wrap_top_addr", 32'(imem_addr_o), 32'd63);
    cyc(); smp();
    check("pc_wrap", 32'(imem_addr_o), 32'd0);
    check("wrap_instr_v", 32'(instr_v_o), 32'd1);
    cyc(); smp();

    cyc(); freeze_i = 1'b1; smp();
    check("frz_no_issue", 32'(imem_v_o), 32'd0);
    check("frz_inflight_v", 32'(instr_v_o), 32'd1);
    check("frz_inflight_instr", instr_o, 32'hC0DE_0001);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check("frz_hold_imem_v", 32'(imem_v_o), 32'd0);
      check("frz_empty", 32'(instr_v_o), 32'd0);
    end
    cyc(); freeze_i = 1'b0; smp();
    check("unfrz_imem_v", 32'(imem_v_o), 32'd1);
    check("unfrz_addr", 32'(imem_addr_o), 32'd2);
    cyc(); smp();

    cyc(); reset_i = 1'b1; instr_yumi_i = 1'b0; smp();
    check("midrst_imem_v", 32'(imem_v_o), 32'd0);
    check("midrst_instr_v", 32'(instr_v_o), 32'd0);
    check("midrst_instr", instr_o, 32'd0);
    check("midrst_pc_plus4", pc_plus4_o, 32'd0);
    cyc(); reset_i = 1'b0; smp();
    check("rst_drops_inflight", 32'(instr_v_o), 32'd0);
    check("rst_restart_addr", 32'(imem_addr_o), 32'd16);
`ifdef VANILLA_FETCH_PERF_CNT_EN
    check("perf_fetch_rst", fetch_cnt_o, 32'd0);
    check("perf_squash_rst", squash_cnt_o, 32'd0);
`endif
    cyc(); smp();
    check("post_rst_instr_v", 32'(instr_v_o), 32'd1);
    check("post_rst_instr", instr_o, 32'hC0DE_0010);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
